// File: rtl/xy2_100_rx_pkg.sv
// -----------------------------------------------------------------------------
// xy2_100_rx_pkg
// Shared definitions for the XY2-100 command receiver: frame geometry, the
// fixed control-bit pattern of a position frame, the line indices used by the
// input synchronizer bank, the deframer FSM state encoding and a parity helper.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps

package xy2_100_rx_pkg;

   // One XY2-100 frame per channel: C2 C1 C0, D15..D0, P (MSB first).
   localparam int XY2_FRAME_BITS = 20;
   localparam int XY2_DATA_BITS  = 16;
   localparam int XY2_CNT_W      = 5;

   // Control bits that mark a 16-bit position command.
   localparam logic [2:0] XY2_CTRL_POS = 3'b001;

   // Bit positions of the four host lines inside the synchronizer bank.
   localparam int XY2_LINES = 4;
   localparam int LN_CLK    = 3;
   localparam int LN_SYNC   = 2;
   localparam int LN_X      = 1;
   localparam int LN_Y      = 0;

   typedef enum logic [1:0] {
      ST_HUNT  = 2'd0,
      ST_RECV  = 2'd1,
      ST_CHECK = 2'd2
   } xy2_state_e;

   // Even parity over the whole frame: all 20 bits XOR to zero.
   function automatic logic xy2_parity_ok(input logic [XY2_FRAME_BITS-1:0] word);
      return ~(^word);
   endfunction

endpackage

// File: rtl/xy2_100_rx_chan.sv
// -----------------------------------------------------------------------------
// xy2_chan_rx
// One XY2-100 data channel (instantiated for X and for Y). Shifts serial bits
// in MSB first and decodes the frame currently held in the shift register.
//
// Ports
//   clk_in    in   1   system clock
//   rst_n     in   1   internal async active-low reset (synchronously released)
//   shift_en  in   1   shift din into the LSB this cycle
//   din       in   1   synchronized serial data bit
//   data      out  16  D15..D0 of the held frame
//   ctrl_ok   out  1   control bits equal the position-command pattern
//   par_ok    out  1   even parity over all 20 held bits
// -----------------------------------------------------------------------------
`timescale 1ns/1ps

module xy2_chan_rx
   import xy2_100_rx_pkg::*;
(
   input  logic                     clk_in,
   input  logic                     rst_n,
   input  logic                     shift_en,
   input  logic                     din,
   output logic [XY2_DATA_BITS-1:0] data,
   output logic                     ctrl_ok,
   output logic                     par_ok
);

   logic [XY2_FRAME_BITS-1:0] sh_q;
   logic [XY2_FRAME_BITS-1:0] sh_d;

   always_comb begin
      // NOTE: default every always_comb output first so no path leaves it
      // unassigned; otherwise synthesis infers a latch.
      sh_d = sh_q;
      if (shift_en) begin
         sh_d = {sh_q[XY2_FRAME_BITS-2:0], din};
      end
   end

   // NOTE: this register is reset even though every frame overwrites it, so
   // ctrl_ok/par_ok are defined from the first cycle rather than X in sim.
   always_ff @(posedge clk_in or negedge rst_n) begin
      if (!rst_n) begin
         sh_q <= '0;
      end else begin
         // NOTE: flops use non-blocking <= so all registers sample pre-edge
         // values; blocking = here would create order-dependent races.
         sh_q <= sh_d;
      end
   end

   assign data    = sh_q[XY2_FRAME_BITS-4:1];
   assign ctrl_ok = (sh_q[XY2_FRAME_BITS-1:XY2_FRAME_BITS-3] == XY2_CTRL_POS);
   assign par_ok  = xy2_parity_ok(sh_q);

endmodule

// File: rtl/xy2_100_rx.sv
// -----------------------------------------------------------------------------
// xy2_100_rx
// XY2-100 galvo command receiver. Oversamples the host's xy_clk/xy_sync/xy_x/
// xy_y lines at clk_in, deframes 20-bit X and Y frames and publishes validated
// 16-bit position setpoints. Tracks link health and counts framing/parity
// errors.
//
// Ports
//   clk_in     in   1      system clock (20 MHz)
//   sys_rstn   in   1      async active-low reset, released synchronously inside
//   xy_clk     in   1      host bit clock (async), data taken on its falling edge
//   xy_sync    in   1      frame sync (async), low on the last bit of a frame
//   xy_x       in   1      X serial data (async)
//   xy_y       in   1      Y serial data (async)
//   xy_status  out  1      link status back to host (mirrors link_ok)
//   x_pos      out  16     last accepted X setpoint
//   y_pos      out  16     last accepted Y setpoint
//   pos_valid  out  1      strobe: x_pos/y_pos updated this cycle
//   link_ok    out  1      good frame seen within TIMEOUT_CYC cycles
//   fmt_err    out  1      strobe: bad bit count or bad control bits
//   par_err    out  1      strobe: parity failure on a well-formed frame
//   err_cnt    out  ERR_W  saturating count of fmt_err/par_err strobes
//   clr_err    in   1      synchronous clear of err_cnt
// -----------------------------------------------------------------------------
`timescale 1ns/1ps

module xy2_100_rx
   import xy2_100_rx_pkg::*;
#(
   parameter int SYNC_STAGES = 2,
   parameter int TIMEOUT_CYC = 2000,
   parameter int ERR_W       = 8
) (
   input  logic                     clk_in,
   input  logic                     sys_rstn,
   input  logic                     xy_clk,
   input  logic                     xy_sync,
   input  logic                     xy_x,
   input  logic                     xy_y,
   output logic                     xy_status,
   output logic [XY2_DATA_BITS-1:0] x_pos,
   output logic [XY2_DATA_BITS-1:0] y_pos,
   output logic                     pos_valid,
   output logic                     link_ok,
   output logic                     fmt_err,
   output logic                     par_err,
   output logic [ERR_W-1:0]         err_cnt,
   input  logic                     clr_err
);

   localparam int                   TMO_W    = $clog2(TIMEOUT_CYC + 1);
   localparam logic [TMO_W-1:0]     TMO_MAX  = TMO_W'(TIMEOUT_CYC);
   localparam logic [XY2_CNT_W-1:0] LAST_CNT = XY2_CNT_W'(XY2_FRAME_BITS - 1);
   localparam logic [ERR_W-1:0]     ERR_MAX  = {ERR_W{1'b1}};

   // ---------------------------------------------------------------------------
   // Reset: asserts asynchronously, releases on a clock edge.
   // ---------------------------------------------------------------------------
   logic [1:0] rst_sync_q;
   logic [1:0] rst_sync_d;
   logic       rst_n;

   assign rst_sync_d = {rst_sync_q[0], 1'b1};
   assign rst_n      = rst_sync_q[1];

   always_ff @(posedge clk_in or negedge sys_rstn) begin
      if (!sys_rstn) begin
         rst_sync_q <= '0;
      end else begin
         rst_sync_q <= rst_sync_d;
      end
   end

   // ---------------------------------------------------------------------------
   // Input synchronizers; all four lines share the same depth so their relative
   // timing at the pins is preserved after synchronization.
   // ---------------------------------------------------------------------------
   logic [SYNC_STAGES-1:0][XY2_LINES-1:0] sync_q;
   logic [SYNC_STAGES-1:0][XY2_LINES-1:0] sync_d;
   logic [XY2_LINES-1:0]                  s_lines;
   logic                                  clk_dly_q;
   logic                                  clk_dly_d;
   logic                                  s_clk;
   logic                                  s_sync;
   logic                                  s_x;
   logic                                  s_y;
   logic                                  bit_stb;

   assign sync_d    = {sync_q[SYNC_STAGES-2:0], {xy_clk, xy_sync, xy_x, xy_y}};
   assign s_lines   = sync_q[SYNC_STAGES-1];
   assign s_clk     = s_lines[LN_CLK];
   assign s_sync    = s_lines[LN_SYNC];
   assign s_x       = s_lines[LN_X];
   assign s_y       = s_lines[LN_Y];
   assign clk_dly_d = s_clk;

   // Falling edge of the synchronized host clock marks one received bit.
   assign bit_stb   = clk_dly_q & ~s_clk;

   always_ff @(posedge clk_in or negedge rst_n) begin
      if (!rst_n) begin
         sync_q    <= '0;
         clk_dly_q <= 1'b0;
      end else begin
         sync_q    <= sync_d;
         clk_dly_q <= clk_dly_d;
      end
   end

   // ---------------------------------------------------------------------------
   // Channel shift registers
   // ---------------------------------------------------------------------------
   logic                     shift_en;
   logic [XY2_DATA_BITS-1:0] x_data;
   logic [XY2_DATA_BITS-1:0] y_data;
   logic                     x_ctrl_ok;
   logic                     y_ctrl_ok;
   logic                     x_par_ok;
   logic                     y_par_ok;

   xy2_chan_rx u_chan_x (
      .clk_in   (clk_in),
      .rst_n    (rst_n),
      .shift_en (shift_en),
      .din      (s_x),
      .data     (x_data),
      .ctrl_ok  (x_ctrl_ok),
      .par_ok   (x_par_ok)
   );

   xy2_chan_rx u_chan_y (
      .clk_in   (clk_in),
      .rst_n    (rst_n),
      .shift_en (shift_en),
      .din      (s_y),
      .data     (y_data),
      .ctrl_ok  (y_ctrl_ok),
      .par_ok   (y_par_ok)
   );

   // ---------------------------------------------------------------------------
   // Deframer FSM, link timeout and error counter
   // ---------------------------------------------------------------------------
   xy2_state_e               state_q,     state_d;
   logic [XY2_CNT_W-1:0]     cnt_q,       cnt_d;
   logic [XY2_DATA_BITS-1:0] x_pos_q,     x_pos_d;
   logic [XY2_DATA_BITS-1:0] y_pos_q,     y_pos_d;
   logic                     pos_valid_q, pos_valid_d;
   logic                     fmt_err_q,   fmt_err_d;
   logic                     par_err_q,   par_err_d;
   logic [TMO_W-1:0]         tmo_q,       tmo_d;
   logic                     seen_q,      seen_d;
   logic                     link_ok_q,   link_ok_d;
   logic [ERR_W-1:0]         err_cnt_q,   err_cnt_d;
   logic                     err_ev;

   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      x_pos_d     = x_pos_q;
      y_pos_d     = y_pos_q;
      pos_valid_d = 1'b0;
      fmt_err_d   = 1'b0;
      par_err_d   = 1'b0;
      shift_en    = 1'b0;

      unique case (state_q)
         ST_HUNT: begin
            // Any sync-low bit ends some frame, so the next bit starts one.
            if (bit_stb && !s_sync) begin
               state_d = ST_RECV;
               cnt_d   = '0;
            end
         end

         ST_RECV: begin
            if (bit_stb) begin
               if (s_sync) begin
                  if (cnt_q == LAST_CNT) begin
                     // A 20th sync-high bit: the frame is too long.
                     fmt_err_d = 1'b1;
                     state_d   = ST_HUNT;
                  end else begin
                     shift_en = 1'b1;
                     cnt_d    = cnt_q + XY2_CNT_W'(1);
                  end
               end else begin
                  shift_en = 1'b1;
                  if (cnt_q == LAST_CNT) begin
                     state_d = ST_CHECK;
                  end else begin
                     // Short frame; this sync-low bit still marks a boundary.
                     fmt_err_d = 1'b1;
                     cnt_d     = '0;
                  end
               end
            end
         end

         ST_CHECK: begin
            state_d = ST_RECV;
            cnt_d   = '0;
            if (!(x_ctrl_ok && y_ctrl_ok)) begin
               fmt_err_d = 1'b1;
            end else if (!(x_par_ok && y_par_ok)) begin
               par_err_d = 1'b1;
            end else begin
               pos_valid_d = 1'b1;
               x_pos_d     = x_data;
               y_pos_d     = y_data;
            end
         end

         default: begin
            state_d = ST_HUNT;
         end
      endcase

      // Link timeout: saturating cycle count since the last accepted frame.
      if (pos_valid_d) begin
         tmo_d = '0;
      end else if (tmo_q < TMO_MAX) begin
         tmo_d = tmo_q + TMO_W'(1);
      end else begin
         tmo_d = tmo_q;
      end
      seen_d    = seen_q | pos_valid_d;
      link_ok_d = pos_valid_d | (seen_q & (tmo_q < TMO_MAX));

      // Error counter follows the registered strobes, so a clear issued while
      // a strobe is visible on the outputs leaves exactly that one error.
      err_ev    = fmt_err_q | par_err_q;
      err_cnt_d = err_cnt_q;
      if (clr_err) begin
         err_cnt_d = err_ev ? ERR_W'(1) : '0;
      end else if (err_ev && (err_cnt_q != ERR_MAX)) begin
         err_cnt_d = err_cnt_q + ERR_W'(1);
      end
   end

   always_ff @(posedge clk_in or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= ST_HUNT;
         cnt_q       <= '0;
         x_pos_q     <= '0;
         y_pos_q     <= '0;
         pos_valid_q <= 1'b0;
         fmt_err_q   <= 1'b0;
         par_err_q   <= 1'b0;
         tmo_q       <= '0;
         seen_q      <= 1'b0;
         link_ok_q   <= 1'b0;
         err_cnt_q   <= '0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         x_pos_q     <= x_pos_d;
         y_pos_q     <= y_pos_d;
         pos_valid_q <= pos_valid_d;
         fmt_err_q   <= fmt_err_d;
         par_err_q   <= par_err_d;
         tmo_q       <= tmo_d;
         seen_q      <= seen_d;
         link_ok_q   <= link_ok_d;
         err_cnt_q   <= err_cnt_d;
      end
   end

   assign x_pos     = x_pos_q;
   assign y_pos     = y_pos_q;
   assign pos_valid = pos_valid_q;
   assign fmt_err   = fmt_err_q;
   assign par_err   = par_err_q;
   assign link_ok   = link_ok_q;
   assign xy_status = link_ok_q;
   assign err_cnt   = err_cnt_q;

endmodule
